gpp_mc_core: RTL and testbench

GPP_MC_CORE -- requirements
Module: gpp_mc_core

---
 rtl/gpp_mc_if.sv | 42 ++++
 rtl/gpp_mc_core.sv | 230 +++++++++++++++++++++++
 tb/tb_gpp_mc_core.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpp_mc_if.sv
// rtl/gpp_mc_if.sv - instruction/data memory bus bundle for the multi-cycle core
//
// Ports carried:
//   imem_req/imem_addr (core -> mem), imem_rdata/imem_ack (mem -> core)
//   dmem_req/dmem_we/dmem_addr/dmem_wdata (core -> mem), dmem_rdata/dmem_ack (mem -> core)
//   halted/retire_cnt (core status)
// Modports: master = core side, slave = memory/observer side.
interface gpp_mc_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic          imem_ack;

    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    logic          halted;
    logic [31:0]   retire_cnt;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack,
        output halted, retire_cnt
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack,
        input  halted, retire_cnt
    );
endinterface

// File: rtl/gpp_mc_core.sv
// rtl/gpp_mc_core.sv - multi-cycle core, 16-bit instructions, 8 x DW register file
//
// Parameters: DW datapath width (16..64), AW address width (AW <= DW),
//             RESET_PC fetch address after reset.
// Ports: clk, rst (async, active-high), bus (gpp_mc_if.master):
//   instruction fetch via imem_req/imem_addr/imem_rdata/imem_ack,
//   loads/stores via dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_rdata/dmem_ack,
//   halted and 32-bit retire_cnt status outputs.
module gpp_mc_core #(
    parameter int            DW       = 16,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic       clk,
    input logic       rst,
    gpp_mc_if.master  bus
);
    localparam int SW = $clog2(DW);

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SLTU = 5'b01000;
    localparam logic [4:0] OP_LDI  = 5'b01001;
    localparam logic [4:0] OP_LD   = 5'b01010;
    localparam logic [4:0] OP_ST   = 5'b01011;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_JR   = 5'b01101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [DW-1:0] regs_q [0:7];
    logic [DW-1:0] regs_d [0:7];
    logic [DW-1:0] res_q, res_d;
    logic          imem_req_q, imem_req_d;
    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [DW-1:0] dmem_wdata_q, dmem_wdata_d;
    logic          halted_q, halted_d;
    logic [31:0]   retire_q, retire_d;

    logic [4:0]    op;
    logic [2:0]    rd_idx, rs_idx, rt_idx;
    logic [7:0]    imm8;
    logic [DW-1:0] rs_val, rt_val, rd_val, imm_sx, alu_res;
    logic          is_alu;

    assign op     = ir_q[15:11];
    assign rd_idx = ir_q[10:8];
    assign rs_idx = ir_q[7:5];
    assign rt_idx = ir_q[4:2];
    assign imm8   = ir_q[7:0];

    // regs_q[0] is held at zero by the update logic, so direct indexing gives R0 = 0
    assign rs_val = regs_q[rs_idx];
    assign rt_val = regs_q[rt_idx];
    assign rd_val = regs_q[rd_idx];
    assign imm_sx = {{(DW-8){imm8[7]}}, imm8};
    assign is_alu = (op >= OP_ADD) && (op <= OP_SLTU);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = rs_val + rt_val;
            OP_SUB:  alu_res = rs_val - rt_val;
            OP_AND:  alu_res = rs_val & rt_val;
            OP_OR:   alu_res = rs_val | rt_val;
            OP_XOR:  alu_res = rs_val ^ rt_val;
            OP_SHL:  alu_res = rs_val << rt_val[SW-1:0];
            OP_SHR:  alu_res = rs_val >> rt_val[SW-1:0];
            OP_SLTU: alu_res = {{(DW-1){1'b0}}, (rs_val < rt_val)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        regs_d       = regs_q;
        res_d        = res_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        halted_d     = halted_q;
        retire_d     = retire_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // qualify with our own request so a stray ack is never consumed
                if (bus.imem_ack && imem_req_q) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu) begin
                    res_d   = alu_res;
                    state_d = S_WB;
                end else begin
                    case (op)
                        OP_LDI: begin
                            res_d   = imm_sx;
                            state_d = S_WB;
                        end
                        OP_LD, OP_ST: begin
                            dmem_addr_d  = rs_val[AW-1:0];
                            dmem_we_d    = (op == OP_ST);
                            dmem_wdata_d = rd_val;
                            state_d      = S_MEM;
                        end
                        OP_BEQZ: begin
                            // pc_q already holds fetch address + 1
                            if (rd_val == '0) begin
                                pc_d = pc_q + imm_sx[AW-1:0];
                            end
                            retire_d = retire_q + 32'd1;
                            state_d  = S_FETCH;
                        end
                        OP_JR: begin
                            pc_d     = rs_val[AW-1:0];
                            retire_d = retire_q + 32'd1;
                            state_d  = S_FETCH;
                        end
                        OP_HALT: begin
                            halted_d = 1'b1;
                            retire_d = retire_q + 32'd1;
                            state_d  = S_HALT;
                        end
                        default: begin
                            retire_d = retire_q + 32'd1;
                            state_d  = S_FETCH;
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (bus.dmem_ack && dmem_req_q) begin
                    if (dmem_we_q) begin
                        retire_d = retire_q + 32'd1;
                        state_d  = S_FETCH;
                    end else begin
                        res_d   = bus.dmem_rdata;
                        state_d = S_WB;
                    end
                    dmem_we_d = 1'b0;
                end
            end
            S_WB: begin
                regs_d[rd_idx] = res_q;
                retire_d       = retire_q + 32'd1;
                state_d        = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        regs_d[0] = '0;

        // requests are registered: they rise together with entry into the owning state
        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            res_q        <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            halted_q     <= 1'b0;
            retire_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            regs_q       <= regs_d;
            res_q        <= res_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            halted_q     <= halted_d;
            retire_q     <= retire_d;
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.halted     = halted_q;
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_gpp_mc_core.sv
// tb/tb_gpp_mc_core.sv - directed bench for gpp_mc_core at two parameter sets
module tb_gpp_mc_core;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SLTU = 5'd8;
    localparam logic [4:0] OP_LDI  = 5'd9;
    localparam logic [4:0] OP_LD   = 5'd10;
    localparam logic [4:0] OP_ST   = 5'd11;
    localparam logic [4:0] OP_BEQZ = 5'd12;
    localparam logic [4:0] OP_JR   = 5'd13;
    localparam logic [15:0] W_HALT = 16'hF800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   i_wait = 0;
    int   d_wait = 0;
    logic force_iack = 1'b0;
    int   pp = 0;

    logic [15:0] prog   [0:255];
    logic [15:0] dmem_a [0:255];
    logic [31:0] dmem_b [0:255];
    logic [16:0] dlog_a [$];
    logic [20:0] dlog_b [$];
    logic [15:0] flog_a [$];
    int   icnt_a = 0, dcnt_a = 0, icnt_b = 0, dcnt_b = 0;
    logic hold_a = 1'b0, hold_b = 1'b0;
    logic unstable_a = 1'b0, unstable_b = 1'b0;
    logic [32:0] hval_a = '0;
    logic [52:0] hval_b = '0;

    gpp_mc_if #(.DW(16), .AW(16)) bus_a ();
    gpp_mc_if #(.DW(32), .AW(20)) bus_b ();

    gpp_mc_core #(.DW(16), .AW(16), .RESET_PC(16'h0000)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    gpp_mc_core #(.DW(32), .AW(20), .RESET_PC(20'h00100)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    assign bus_a.imem_ack   = force_iack | (bus_a.imem_req && icnt_a == i_wait);
    assign bus_a.imem_rdata = prog[bus_a.imem_addr[7:0]];
    assign bus_a.dmem_ack   = bus_a.dmem_req && dcnt_a == d_wait;
    assign bus_a.dmem_rdata = dmem_a[bus_a.dmem_addr[7:0]];
    assign bus_b.imem_ack   = bus_b.imem_req && icnt_b == i_wait;
    assign bus_b.imem_rdata = prog[bus_b.imem_addr[7:0]];
    assign bus_b.dmem_ack   = bus_b.dmem_req && dcnt_b == d_wait;
    assign bus_b.dmem_rdata = dmem_b[bus_b.dmem_addr[7:0]];

    always @(posedge clk) begin
        icnt_a <= (bus_a.imem_req && !bus_a.imem_ack) ? icnt_a + 1 : 0;
        dcnt_a <= (bus_a.dmem_req && !bus_a.dmem_ack) ? dcnt_a + 1 : 0;
        if (bus_a.imem_req && bus_a.imem_ack) flog_a.push_back(bus_a.imem_addr);
        if (bus_a.dmem_req && bus_a.dmem_ack) begin
            if (bus_a.dmem_we) dmem_a[bus_a.dmem_addr[7:0]] <= bus_a.dmem_wdata;
            dlog_a.push_back({bus_a.dmem_we, bus_a.dmem_addr});
        end
        if (hold_a && bus_a.dmem_req && ({bus_a.dmem_we, bus_a.dmem_addr, bus_a.dmem_wdata} !== hval_a))
            unstable_a <= 1'b1;
        hold_a <= bus_a.dmem_req && !bus_a.dmem_ack;
        hval_a <= {bus_a.dmem_we, bus_a.dmem_addr, bus_a.dmem_wdata};
    end

    always @(posedge clk) begin
        icnt_b <= (bus_b.imem_req && !bus_b.imem_ack) ? icnt_b + 1 : 0;
        dcnt_b <= (bus_b.dmem_req && !bus_b.dmem_ack) ? dcnt_b + 1 : 0;
        if (bus_b.dmem_req && bus_b.dmem_ack) begin
            if (bus_b.dmem_we) dmem_b[bus_b.dmem_addr[7:0]] <= bus_b.dmem_wdata;
            dlog_b.push_back({bus_b.dmem_we, bus_b.dmem_addr});
        end
        if (hold_b && bus_b.dmem_req && ({bus_b.dmem_we, bus_b.dmem_addr, bus_b.dmem_wdata} !== hval_b))
            unstable_b <= 1'b1;
        hold_b <= bus_b.dmem_req && !bus_b.dmem_ack;
        hval_b <= {bus_b.dmem_we, bus_b.dmem_addr, bus_b.dmem_wdata};
    end

    function automatic logic [15:0] r3(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 2'b00};
    endfunction

    function automatic logic [15:0] i8(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic put(input logic [15:0] w);
        prog[pp] = w;
        pp = pp + 1;
    endtask

    task automatic put_at(input int idx, input logic [15:0] w);
        prog[idx] = w;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
        pp = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [15:0] exp2  [0:8];
    logic [15:0] expf  [0:10];
    int          nreq;
    int          fbase;

    initial begin
        exp2 = '{16'h0000, 16'hFFFF, 16'h0005, 16'h3FFF, 16'h0001,
                 16'h0000, 16'hFFFA, 16'h0002, 16'h0007};
        expf = '{16'h0000, 16'h0001, 16'h0004, 16'h0005, 16'hFFFF,
                 16'h0001, 16'h0002, 16'h0003, 16'h0007, 16'h0007, 16'h0007};

        // Scenario 1+2: ALU chain, store/load through 3-wait dmem, both widths
        clear_prog();
        put(i8(OP_LDI, 3'd1, 8'd5));
        put(i8(OP_LDI, 3'd2, 8'hFD));
        put(r3(OP_ADD, 3'd3, 3'd1, 3'd2));
        put(i8(OP_LDI, 3'd4, 8'h10));
        put(r3(OP_ST,  3'd1, 3'd4, 3'd0));
        put(r3(OP_LD,  3'd5, 3'd4, 3'd0));
        put(i8(OP_LDI, 3'd6, 8'h11));
        put(r3(OP_ST,  3'd5, 3'd6, 3'd0));
        put(i8(OP_LDI, 3'd6, 8'h12));
        put(r3(OP_ST,  3'd3, 3'd6, 3'd0));
        put(i8(OP_LDI, 3'd6, 8'h13));
        put(r3(OP_ST,  3'd2, 3'd6, 3'd0));
        put(W_HALT);
        i_wait = 0;
        d_wait = 3;

        repeat (3) @(negedge clk);
        chk("rst_imem_req", bus_a.imem_req, 0);
        chk("rst_dmem_req", bus_a.dmem_req, 0);
        chk("rst_dmem_we", bus_a.dmem_we, 0);
        chk("rst_halted", bus_a.halted, 0);
        chk("rst_retire", bus_a.retire_cnt, 0);
        chk("rst_pc_b", bus_b.imem_addr, 20'h00100);

        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("idle_no_req", bus_a.imem_req, 0);
        @(negedge clk);
        chk("first_req_a", bus_a.imem_req, 1);
        chk("first_addr_a", bus_a.imem_addr, 16'h0000);
        chk("first_req_b", bus_b.imem_req, 1);
        chk("first_addr_b", bus_b.imem_addr, 20'h00100);
        repeat (8) @(negedge clk);
        chk("retire_8cyc", bus_a.retire_cnt, 2);
        @(negedge clk);
        chk("retire_9cyc_a", bus_a.retire_cnt, 3);
        chk("retire_9cyc_b", bus_b.retire_cnt, 3);
        chk("fetch4_addr_a", bus_a.imem_addr, 16'h0003);
        chk("fetch4_addr_b", bus_b.imem_addr, 20'h00103);

        for (int i = 0; i < 400 && !(bus_a.halted && bus_b.halted); i++) @(negedge clk);
        chk("halted_a", bus_a.halted, 1);
        chk("halted_b", bus_b.halted, 1);
        chk("retire_total_a", bus_a.retire_cnt, 13);
        chk("retire_total_b", bus_b.retire_cnt, 13);
        chk("dlog_size_a", dlog_a.size(), 5);
        chk("dlog_size_b", dlog_b.size(), 5);
        if (dlog_a.size() >= 2) begin
            chk("st_we_addr_a", dlog_a[0], {1'b1, 16'h0010});
            chk("ld_we_addr_a", dlog_a[1], {1'b0, 16'h0010});
        end
        if (dlog_b.size() >= 2) begin
            chk("st_we_addr_b", dlog_b[0], {1'b1, 20'h00010});
            chk("ld_we_addr_b", dlog_b[1], {1'b0, 20'h00010});
        end
        chk("dmem_stable_a", unstable_a, 0);
        chk("dmem_stable_b", unstable_b, 0);
        chk("mem10_a", dmem_a[8'h10], 16'h0005);
        chk("ld_r5_a", dmem_a[8'h11], 16'h0005);
        chk("add_r3_a", dmem_a[8'h12], 16'h0002);
        chk("ldi_neg_a", dmem_a[8'h13], 16'hFFFD);
        chk("ld_r5_b", dmem_b[8'h11], 32'h0000_0005);
        chk("add_r3_b", dmem_b[8'h12], 32'h0000_0002);
        chk("ldi_neg_b", dmem_b[8'h13], 32'hFFFF_FFFD);

        nreq = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_a.imem_req || bus_a.dmem_req) nreq++;
        end
        chk("halt_no_req", nreq, 0);
        chk("halt_retire_frozen", bus_a.retire_cnt, 13);
        chk("halt_still", bus_a.halted, 1);

        // Scenario 3: R0 discard, wrap, shift-amount masking, compares, illegal opcode
        rst_a = 1'b1;
        rst_b = 1'b1;
        d_wait = 0;
        clear_prog();
        put(i8(OP_LDI, 3'd1, 8'd5));
        put(r3(OP_ADD, 3'd0, 3'd1, 3'd1));
        put(r3(OP_ADD, 3'd6, 3'd0, 3'd0));
        put(i8(OP_LDI, 3'd4, 8'h20)); put(r3(OP_ST, 3'd6, 3'd4, 3'd0));
        put(i8(OP_LDI, 3'd2, 8'd1));
        put(r3(OP_SUB, 3'd7, 3'd0, 3'd2));
        put(i8(OP_LDI, 3'd4, 8'h21)); put(r3(OP_ST, 3'd7, 3'd4, 3'd0));
        put(i8(OP_LDI, 3'd3, 8'd16));
        put(r3(OP_SHL, 3'd5, 3'd1, 3'd3));
        put(i8(OP_LDI, 3'd4, 8'h22)); put(r3(OP_ST, 3'd5, 3'd4, 3'd0));
        put(i8(OP_LDI, 3'd3, 8'd2));
        put(r3(OP_SHR, 3'd5, 3'd7, 3'd3));
        put(i8(OP_LDI, 3'd4, 8'h23)); put(r3(OP_ST, 3'd5, 3'd4, 3'd0));
        put(r3(OP_SLTU, 3'd5, 3'd1, 3'd7));
        put(i8(OP_LDI, 3'd4, 8'h24)); put(r3(OP_ST, 3'd5, 3'd4, 3'd0));
        put(r3(OP_SLTU, 3'd5, 3'd7, 3'd1));
        put(i8(OP_LDI, 3'd4, 8'h25)); put(r3(OP_ST, 3'd5, 3'd4, 3'd0));
        put(r3(OP_XOR, 3'd5, 3'd7, 3'd1));
        put(i8(OP_LDI, 3'd4, 8'h26)); put(r3(OP_ST, 3'd5, 3'd4, 3'd0));
        put(r3(OP_AND, 3'd5, 3'd7, 3'd3));
        put(i8(OP_LDI, 3'd4, 8'h27)); put(r3(OP_ST, 3'd5, 3'd4, 3'd0));
        put(r3(OP_OR, 3'd5, 3'd1, 3'd3));
        put(i8(OP_LDI, 3'd4, 8'h28)); put(r3(OP_ST, 3'd5, 3'd4, 3'd0));
        put(16'h8000);
        put(16'h0000);
        put(W_HALT);
        repeat (2) @(negedge clk);
        chk("rst2_retire", bus_a.retire_cnt, 0);
        chk("rst2_halted", bus_a.halted, 0);
        rst_a = 1'b0;
        for (int i = 0; i < 600 && !bus_a.halted; i++) @(negedge clk);
        chk("alu_halted", bus_a.halted, 1);
        chk("alu_retire", bus_a.retire_cnt, 35);
        for (int k = 0; k < 9; k++)
            chk($sformatf("alu_res_%0d", k), dmem_a[8'h20 + k], exp2[k]);

        // Scenario 4: BEQZ taken/not-taken, JR, PC wrap at 0xFFFF
        rst_a = 1'b1;
        clear_prog();
        put_at(0,   i8(OP_LDI,  3'd1, 8'hFF));
        put_at(1,   i8(OP_BEQZ, 3'd2, 8'd2));
        put_at(2,   i8(OP_LDI,  3'd3, 8'd7));
        put_at(3,   r3(OP_JR,   3'd0, 3'd3, 3'd0));
        put_at(4,   i8(OP_LDI,  3'd2, 8'd1));
        put_at(5,   r3(OP_JR,   3'd0, 3'd1, 3'd0));
        put_at(7,   i8(OP_BEQZ, 3'd0, 8'hFF));
        put_at(255, i8(OP_BEQZ, 3'd0, 8'd1));
        @(negedge clk);
        fbase = flog_a.size();
        rst_a = 1'b0;
        for (int i = 0; i < 300 && flog_a.size() < fbase + 11; i++) @(negedge clk);
        chk("branch_fetch_count", (flog_a.size() >= fbase + 11), 1);
        if (flog_a.size() >= fbase + 11) begin
            for (int k = 0; k < 11; k++)
                chk($sformatf("branch_fetch_%0d", k), flog_a[fbase + k], expf[k]);
        end

        // Scenario 5: reset while a fetch is waiting, with an ack arriving around reset
        i_wait = 5;
        repeat (3) @(negedge clk);
        chk("pre_rst_req", bus_a.imem_req, 1);
        chk("pre_rst_addr", bus_a.imem_addr, 16'h0007);
        rst_a = 1'b1;
        #1;
        chk("rst_drops_req", bus_a.imem_req, 0);
        @(posedge clk);
        #1;
        force_iack = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("rel_idle_req", bus_a.imem_req, 0);
        @(posedge clk);
        #1;
        force_iack = 1'b0;
        chk("rel_fetch_req", bus_a.imem_req, 1);
        chk("rel_fetch_addr", bus_a.imem_addr, 16'h0000);
        chk("rel_retire", bus_a.retire_cnt, 0);
        chk("rel_halted", bus_a.halted, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
